video_out_adapter: RTL and testbench

- Parametrised successor to the per-core video glue: converts a core's native pixel stream (R/G/B, blanks, syncs, CE_PIXEL) into the Pocket video_if signal set (rgb, de, skip, hs, vs).
- Runs entirely in the core clock domain and sits between the arcade core and the video_if scaler output.
- Over fixed glue it adds:
  - configurable colour depth and expansion mode;
  - configurable sync polarity;
  - N-cycle CE stretch;
  - frame-lock state machine that suppresses partial frames;
  - line-count watchdog.

---
 rtl/video_out_adapter.sv | 278 +++++++++++++++++++++++++++
 tb/tb_video_out_adapter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_out_adapter.sv
// -----------------------------------------------------------------------------
// video_out_adapter
//
// Converts an arcade core's native pixel stream (R/G/B, blanks, syncs,
// ce_pixel) into the Pocket video_if signal set (rgb, de, skip, hs, vs).
// Everything runs in the core clock domain. Every output is registered, and
// rgb/de/skip/hs/vs are one clk behind the inputs and aligned with each other.
//
// Parameters
//   IN_BITS    bits per colour channel from the core (1..8)
//   REPLICATE  1 = expand to 8 bits by MSB replication, 0 = zero-pad LSBs
//   SYNC_POS   1 = syncs active-high (rising edge is the event), 0 = falling
//   CE_STRETCH clk cycles each ce_pixel is held for skip generation (1..8)
//   MAX_LINES  hs events without a vs before lock is dropped
//   CNT_W      width of line/pixel counters
//
// Ports
//   clk            core pixel-domain clock
//   reset          synchronous, active-high
//   ce_pixel       core pixel enable
//   hblank/vblank  core blanking
//   hsync/vsync    core syncs (polarity set by SYNC_POS)
//   r_in/g_in/b_in core colour, IN_BITS each
//   scanline       (VIDEO_OUT_SCANLINE_EN only) dim odd lines to 75%
//   out_rgb        {R8,G8,B8}, zero outside de
//   out_de         data enable
//   out_skip       de cycle carrying no new pixel
//   out_hs/out_vs  one-clk sync events
//   frame_locked   adapter is passing video
//   active_width   measured pixels per line
//   active_height  measured active lines per frame
//   measure_valid  width/height hold a complete measurement
//
// Optional feature: define VIDEO_OUT_SCANLINE_EN to add the scanline input.
// -----------------------------------------------------------------------------
module video_out_adapter #(
  parameter int IN_BITS    = 4,
  parameter int REPLICATE  = 1,
  parameter int SYNC_POS   = 1,
  parameter int CE_STRETCH = 2,
  parameter int MAX_LINES  = 300,
  parameter int CNT_W      = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce_pixel,
  input  logic               hblank,
  input  logic               vblank,
  input  logic               hsync,
  input  logic               vsync,
  input  logic [IN_BITS-1:0] r_in,
  input  logic [IN_BITS-1:0] g_in,
  input  logic [IN_BITS-1:0] b_in,
`ifdef VIDEO_OUT_SCANLINE_EN
  input  logic               scanline,
`endif
  output logic [23:0]        out_rgb,
  output logic               out_de,
  output logic               out_skip,
  output logic               out_hs,
  output logic               out_vs,
  output logic               frame_locked,
  output logic [CNT_W-1:0]   active_width,
  output logic [CNT_W-1:0]   active_height,
  output logic               measure_valid
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int                HOLD_W      = 4;
  localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(CE_STRETCH - 1);
  localparam logic [CNT_W:0]    MAX_LINES_C = (CNT_W + 1)'(MAX_LINES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Sync edge detection. Syncs are normalised to "1 = active" first so the
  // history registers reset to 0, the inactive level, and no event can fire
  // on the first cycle after reset.
  // ---------------------------------------------------------------------------
  logic hs_act, vs_act;
  logic hs_act_reg, vs_act_reg;
  logic ev_hs, ev_vs;

  assign hs_act = (SYNC_POS != 0) ? hsync : ~hsync;
  assign vs_act = (SYNC_POS != 0) ? vsync : ~vsync;
  assign ev_hs  = hs_act & ~hs_act_reg;
  assign ev_vs  = vs_act & ~vs_act_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_act_reg <= 1'b0;
      vs_act_reg <= 1'b0;
    end else begin
      hs_act_reg <= hs_act;
      vs_act_reg <= vs_act;
    end
  end

  // ---------------------------------------------------------------------------
  // CE stretch. A down-counter reloaded on every ce_pixel is equivalent to
  // OR-ing the previous CE_STRETCH-1 ce samples; CE_STRETCH=1 loads zero, so
  // ce_held collapses to ce_pixel.
  // ---------------------------------------------------------------------------
  logic [HOLD_W-1:0] ce_hold_reg;
  logic              ce_held;

  assign ce_held = ce_pixel | (ce_hold_reg != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ce_hold_reg <= '0;
    end else if (ce_pixel) begin
      ce_hold_reg <= HOLD_LOAD;
    end else if (ce_hold_reg != '0) begin
      ce_hold_reg <= ce_hold_reg - 1'b1;
    end
  end

  logic raw_de;
  assign raw_de = ~hblank & ~vblank;

  // ---------------------------------------------------------------------------
  // Colour expansion to 8 bits per channel. Bit 7-gi takes input bit
  // (gi mod IN_BITS) counted from the MSB, which repeats the value MSB-first;
  // IN_BITS=8 degenerates to a straight copy in both modes.
  // ---------------------------------------------------------------------------
  logic [7:0] r_exp, g_exp, b_exp;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_expand
      if (REPLICATE != 0) begin : g_rep
        assign r_exp[7-gi] = r_in[IN_BITS-1-(gi % IN_BITS)];
        assign g_exp[7-gi] = g_in[IN_BITS-1-(gi % IN_BITS)];
        assign b_exp[7-gi] = b_in[IN_BITS-1-(gi % IN_BITS)];
      end else if (gi < IN_BITS) begin : g_copy
        assign r_exp[7-gi] = r_in[IN_BITS-1-gi];
        assign g_exp[7-gi] = g_in[IN_BITS-1-gi];
        assign b_exp[7-gi] = b_in[IN_BITS-1-gi];
      end else begin : g_pad
        assign r_exp[7-gi] = 1'b0;
        assign g_exp[7-gi] = 1'b0;
        assign b_exp[7-gi] = 1'b0;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Frame-lock FSM state and line counter
  // ---------------------------------------------------------------------------
  state_t           state_reg;
  logic [CNT_W-1:0] line_cnt_reg;
  logic             watchdog_trip;
  logic             pass;

  // A further hs once the counter has reached MAX_LINES, with no vs alongside
  // it, means the frame structure was lost. vs takes priority over hs.
  assign watchdog_trip = (state_reg == LOCKED) && ev_hs && !ev_vs &&
                         ({1'b0, line_cnt_reg} >= MAX_LINES_C);

  // Video passes while locked, except on the tripping hs. The vs that takes
  // HUNT to LOCKED is itself passed so the frame begins with out_vs.
  assign pass = (state_reg == LOCKED) ? ~watchdog_trip : ev_vs;

  logic [23:0] rgb_exp, rgb_px;
  assign rgb_exp = {r_exp, g_exp, b_exp};

`ifdef VIDEO_OUT_SCANLINE_EN
  function automatic logic [7:0] dim75(input logic [7:0] v);
    return (v >> 1) + (v >> 2);
  endfunction

  assign rgb_px = (scanline && line_cnt_reg[0]) ?
                  {dim75(r_exp), dim75(g_exp), dim75(b_exp)} : rgb_exp;
`else
  assign rgb_px = rgb_exp;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= HUNT;
      line_cnt_reg  <= '0;
      out_rgb       <= '0;
      out_de        <= 1'b0;
      out_skip      <= 1'b0;
      out_hs        <= 1'b0;
      out_vs        <= 1'b0;
      frame_locked  <= 1'b0;
      measure_valid <= 1'b0;
    end else begin
      out_de   <= pass & raw_de;
      out_skip <= pass & raw_de & ~ce_held;
      out_hs   <= pass & ev_hs;
      out_vs   <= pass & ev_vs;
      out_rgb  <= (pass && raw_de) ? rgb_px : 24'h0;

      case (state_reg)
        HUNT: begin
          if (ev_vs) begin
            state_reg    <= LOCKED;
            frame_locked <= 1'b1;
            line_cnt_reg <= '0;
          end
        end
        LOCKED: begin
          if (ev_vs) begin
            line_cnt_reg  <= '0;
            // A vs seen while already locked closes a complete frame.
            measure_valid <= 1'b1;
          end else if (watchdog_trip) begin
            state_reg     <= HUNT;
            frame_locked  <= 1'b0;
            line_cnt_reg  <= '0;
            measure_valid <= 1'b0;
          end else if (ev_hs) begin
            line_cnt_reg <= sat_inc(line_cnt_reg);
          end
        end
        default: begin
          state_reg    <= HUNT;
          frame_locked <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Active-area measurement. Runs independently of lock so numbers are ready
  // as soon as the first full locked frame completes.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] pix_cnt_reg;
  logic [CNT_W-1:0] act_lines_reg;
  logic             line_had_de_reg;
  logic             line_done;

  // The current line counts as active if it showed de earlier or shows it now.
  assign line_done = line_had_de_reg | raw_de;

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt_reg     <= '0;
      act_lines_reg   <= '0;
      line_had_de_reg <= 1'b0;
      active_width    <= '0;
      active_height   <= '0;
    end else begin
      if (ev_hs) begin
        // Blank lines carry no pixels and must not overwrite the last width.
        if (pix_cnt_reg != '0) begin
          active_width <= pix_cnt_reg;
        end
        pix_cnt_reg <= '0;
      end else if (ce_pixel && raw_de) begin
        pix_cnt_reg <= sat_inc(pix_cnt_reg);
      end

      if (ev_vs) begin
        active_height   <= line_done ? sat_inc(act_lines_reg) : act_lines_reg;
        act_lines_reg   <= '0;
        line_had_de_reg <= 1'b0;
      end else if (ev_hs) begin
        if (line_done) begin
          act_lines_reg <= sat_inc(act_lines_reg);
        end
        line_had_de_reg <= 1'b0;
      end else if (raw_de) begin
        line_had_de_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_out_adapter.sv
// -----------------------------------------------------------------------------
// tb_video_out_adapter
//
// Two adapters share one stimulus stream:
//   dut_a : IN_BITS=4, REPLICATE=1, SYNC_POS=1, CE_STRETCH=2, MAX_LINES=300
//   dut_b : IN_BITS=4, REPLICATE=0, SYNC_POS=0, CE_STRETCH=1, MAX_LINES=4
// dut_b sees inverted syncs, so both experience the same sync events.
// A behavioural model per instance predicts every output each cycle; directed
// phases add fixed expected values taken from the video rules.
// -----------------------------------------------------------------------------
module tb_video_out_adapter;

  localparam int IN_BITS = 4;
  localparam int CNT_W   = 12;
  localparam int CNT_SAT = (1 << CNT_W) - 1;
  localparam int AGE_MAX = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, ce_pixel, hblank, vblank, hs_lvl, vs_lvl;
  logic [IN_BITS-1:0] r_in, g_in, b_in;
  logic               hsync_n, vsync_n;

  assign hsync_n = ~hs_lvl;
  assign vsync_n = ~vs_lvl;

  logic [23:0]      a_rgb, b_rgb;
  logic             a_de, a_skip, a_hs, a_vs, a_lock, a_mv;
  logic             b_de, b_skip, b_hs, b_vs, b_lock, b_mv;
  logic [CNT_W-1:0] a_w, a_h, b_w, b_h;

  video_out_adapter #(
    .IN_BITS(4), .REPLICATE(1), .SYNC_POS(1), .CE_STRETCH(2),
    .MAX_LINES(300), .CNT_W(CNT_W)
  ) dut_a (
    .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .hblank(hblank),
    .vblank(vblank), .hsync(hs_lvl), .vsync(vs_lvl),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .out_rgb(a_rgb), .out_de(a_de), .out_skip(a_skip), .out_hs(a_hs),
    .out_vs(a_vs), .frame_locked(a_lock), .active_width(a_w),
    .active_height(a_h), .measure_valid(a_mv)
  );

  video_out_adapter #(
    .IN_BITS(4), .REPLICATE(0), .SYNC_POS(0), .CE_STRETCH(1),
    .MAX_LINES(4), .CNT_W(CNT_W)
  ) dut_b (
    .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .hblank(hblank),
    .vblank(vblank), .hsync(hsync_n), .vsync(vsync_n),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .out_rgb(b_rgb), .out_de(b_de), .out_skip(b_skip), .out_hs(b_hs),
    .out_vs(b_vs), .frame_locked(b_lock), .active_width(b_w),
    .active_height(b_h), .measure_valid(b_mv)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {
    int rep; int stretch; int maxl;
    bit locked; int line_cnt; bit hs_prev; bit vs_prev; int ce_age;
    int pix; int act; bit had; int width; int height; bit valid;
    bit de; bit skip; bit hs; bit vs; int rgb;
  } model_t;

  model_t m [2];

  function automatic int sat(int v);
    return (v > CNT_SAT) ? CNT_SAT : v;
  endfunction

  // Repeat the value MSB-first until at least 8 bits, keep the top 8.
  function automatic int expand(int v, int rep);
    int acc;
    int bits;
    acc  = 0;
    bits = 0;
    if (rep == 0) return (v << (8 - IN_BITS)) & 255;
    while (bits < 8) begin
      acc  = (acc << IN_BITS) | v;
      bits = bits + IN_BITS;
    end
    return (acc >> (bits - 8)) & 255;
  endfunction

  function automatic model_t model_step(model_t s, bit rst, bit ce, bit hb,
                                        bit vb, bit hs, bit vs,
                                        int r, int g, int b);
    model_t n;
    bit ev_h, ev_v, held, de_raw, pass, line_done;
    n = s;
    if (rst) begin
      n.locked = 0; n.line_cnt = 0; n.hs_prev = 0; n.vs_prev = 0;
      n.ce_age = AGE_MAX; n.pix = 0; n.act = 0; n.had = 0;
      n.width = 0; n.height = 0; n.valid = 0;
      n.de = 0; n.skip = 0; n.hs = 0; n.vs = 0; n.rgb = 0;
      return n;
    end
    ev_h   = hs && !s.hs_prev;
    ev_v   = vs && !s.vs_prev;
    // ce_age = samples since the last ce (1 = previous cycle)
    held   = ce || (s.ce_age < s.stretch);
    de_raw = !hb && !vb;
    if (!s.locked) begin
      pass = ev_v; n.locked = ev_v; n.line_cnt = 0;
    end else if (ev_v) begin
      pass = 1; n.line_cnt = 0; n.valid = 1;
    end else if (ev_h && s.line_cnt >= s.maxl) begin
      pass = 0; n.locked = 0; n.line_cnt = 0; n.valid = 0;
    end else begin
      pass = 1;
      if (ev_h) n.line_cnt = sat(s.line_cnt + 1);
    end
    n.de   = pass && de_raw;
    n.skip = n.de && !held;
    n.hs   = pass && ev_h;
    n.vs   = pass && ev_v;
    n.rgb  = n.de ? ((expand(r, s.rep) << 16) | (expand(g, s.rep) << 8) |
                     expand(b, s.rep)) : 0;
    if (ev_h) begin
      if (s.pix != 0) n.width = s.pix;
      n.pix = 0;
    end else if (ce && de_raw) begin
      n.pix = sat(s.pix + 1);
    end
    line_done = s.had || de_raw;
    if (ev_v) begin
      n.height = sat(s.act + int'(line_done)); n.act = 0; n.had = 0;
    end else if (ev_h) begin
      if (line_done) n.act = sat(s.act + 1);
      n.had = 0;
    end else if (de_raw) begin
      n.had = 1;
    end
    n.hs_prev = hs;
    n.vs_prev = vs;
    n.ce_age  = ce ? 1 : ((s.ce_age < AGE_MAX) ? s.ce_age + 1 : AGE_MAX);
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Comparison helpers
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk1(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk24(string tag, logic [23:0] obs, logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(int i, logic [23:0] rgb, logic de, logic skip,
                           logic hs, logic vs, logic lk, logic [CNT_W-1:0] w,
                           logic [CNT_W-1:0] h, logic mv);
    string p;
    p = (i == 0) ? "a" : "b";
    chk24({p, ".rgb"},    rgb,     24'(m[i].rgb));
    chk1 ({p, ".de"},     de,      m[i].de);
    chk1 ({p, ".skip"},   skip,    m[i].skip);
    chk1 ({p, ".hs"},     hs,      m[i].hs);
    chk1 ({p, ".vs"},     vs,      m[i].vs);
    chk1 ({p, ".locked"}, lk,      m[i].locked);
    chk24({p, ".width"},  24'(w),  24'(m[i].width));
    chk24({p, ".height"}, 24'(h),  24'(m[i].height));
    chk1 ({p, ".mvalid"}, mv,      m[i].valid);
  endtask

  // One clk: the model consumes the inputs present at the edge, outputs are
  // compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      m[i] = model_step(m[i], reset, ce_pixel, hblank, vblank, hs_lvl, vs_lvl,
                        int'(r_in), int'(g_in), int'(b_in));
    #1;
    check_dut(0, a_rgb, a_de, a_skip, a_hs, a_vs, a_lock, a_w, a_h, a_mv);
    check_dut(1, b_rgb, b_de, b_skip, b_hs, b_vs, b_lock, b_w, b_h, b_mv);
  endtask

  task automatic drive_px(bit rst, bit ce, bit hb, bit vb, bit hs, bit vs,
                          logic [IN_BITS-1:0] r, logic [IN_BITS-1:0] g,
                          logic [IN_BITS-1:0] b);
    reset = rst; ce_pixel = ce; hblank = hb; vblank = vb;
    hs_lvl = hs; vs_lvl = vs; r_in = r; g_in = g; b_in = b;
    tick();
  endtask

  task automatic drive(bit rst, bit ce, bit hb, bit vb, bit hs, bit vs);
    drive_px(rst, ce, hb, vb, hs, vs, IN_BITS'($urandom), IN_BITS'($urandom),
             IN_BITS'($urandom));
  endtask

  // npix cycles of picture (ce every clk), then 4 cycles hblank with hs pulse
  task automatic video_line(int npix, bit vb);
    for (int k = 0; k < npix; k++) drive(0, 1, 0, vb, 0, 0);
    drive(0, 0, 1, vb, 1, 0);
    drive(0, 0, 1, vb, 1, 0);
    drive(0, 0, 1, vb, 0, 0);
    drive(0, 0, 1, vb, 0, 0);
  endtask

  task automatic vs_event();
    drive(0, 0, 1, 1, 0, 1);
    drive(0, 0, 1, 1, 0, 1);
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int cnt_a;
    int cnt_b;

    m[0] = '{default: 0};
    m[1] = '{default: 0};
    m[0].rep = 1; m[0].stretch = 2; m[0].maxl = 300; m[0].ce_age = AGE_MAX;
    m[1].rep = 0; m[1].stretch = 1; m[1].maxl = 4;   m[1].ce_age = AGE_MAX;

    // Reset
    for (int k = 0; k < 3; k++) drive(1, 1, 0, 0, 0, 0);
    chk24("reset.a.rgb", a_rgb, 24'h0);
    chk1 ("reset.a.locked", a_lock, 1'b0);
    chk1 ("reset.b.vs", b_vs, 1'b0);
    chk24("reset.a.width", 24'(a_w), 24'h0);
    chk1 ("reset.a.mvalid", a_mv, 1'b0);
    $display("[%0t] reset applied", $time);

    // Active pixels without any vsync: nothing passes
    cnt_a = 0;
    for (int k = 0; k < 20; k++) begin
      drive(0, 1'($urandom), 0, 0, 1'(k % 6 == 2), 0);
      cnt_a += int'(a_de) + int'(b_de);
    end
    chk_int("novs.de_count", cnt_a, 0);
    chk1("novs.a.locked", a_lock, 1'b0);
    $display("[%0t] pixels without vsync: de cycles seen %0d", $time, cnt_a);

    // vsync edge locks, out_vs one clk wide
    drive(0, 0, 1, 1, 0, 1);
    chk1("lock.a.vs", a_vs, 1'b1);
    chk1("lock.b.vs", b_vs, 1'b1);
    chk1("lock.a.locked", a_lock, 1'b1);
    chk1("lock.b.locked", b_lock, 1'b1);
    drive(0, 0, 1, 1, 0, 1);
    chk1("lock.a.vs_width", a_vs, 1'b0);
    drive(0, 0, 1, 1, 0, 0);
    $display("[%0t] vsync edge: lock a=%0b b=%0b", $time, a_lock, b_lock);

    // Colour expansion
    drive_px(0, 1, 0, 0, 0, 0, 4'hA, 4'h3, 4'hF);
    chk24("colour.a.replicate", a_rgb, 24'hAA33FF);
    chk24("colour.b.zeropad", b_rgb, 24'hA030F0);
    drive_px(0, 1, 1, 0, 0, 0, 4'hA, 4'h3, 4'hF);
    chk24("colour.a.blank", a_rgb, 24'h0);
    chk24("colour.b.blank", b_rgb, 24'h0);
    $display("[%0t] colour A/3/F: blank rgb a=%06h b=%06h", $time, a_rgb, b_rgb);

    // CE stretch skip pattern, ce every 4th clk
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      drive(0, 1'(k % 4 == 0), 0, 0, 0, 0);
      chk1("skip.a.pattern", a_skip, 1'(k % 4 >= 2));
      chk1("skip.b.pattern", b_skip, 1'(k % 4 != 0));
    end
    $display("[%0t] skip pattern over 16 clks", $time);

    // Long sync pulse: one event per edge, none on release
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 30; k++) begin
      drive(0, 0, 1, 0, 1, 0);
      if (k == 0) begin
        chk1("sync.a.first", a_hs, 1'b1);
        chk1("sync.b.first", b_hs, 1'b1);
      end
      cnt_a += int'(a_hs); cnt_b += int'(b_hs);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 0, 0, 0);
      cnt_a += int'(a_hs); cnt_b += int'(b_hs);
    end
    chk_int("sync.a.pulses", cnt_a, 1);
    chk_int("sync.b.pulses", cnt_b, 1);
    $display("[%0t] 30-clk sync pulse: events a=%0d b=%0d", $time, cnt_a, cnt_b);

    // Watchdog on dut_b (MAX_LINES=4)
    vs_event();
    cnt_a = 0; cnt_b = 0;
    for (int e = 0; e < 5; e++) begin
      drive(0, 0, 1, 0, 1, 0);
      cnt_a += int'(a_hs); cnt_b += int'(b_hs);
      if (e == 4) begin
        chk1("wdog.b.hs5", b_hs, 1'b0);
        chk1("wdog.b.locked", b_lock, 1'b0);
        chk1("wdog.a.locked", a_lock, 1'b1);
      end
      drive(0, 0, 1, 0, 1, 0);
      drive(0, 0, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
    end
    chk_int("wdog.a.hs_count", cnt_a, 5);
    chk_int("wdog.b.hs_count", cnt_b, 4);
    drive(0, 0, 1, 1, 0, 1);
    chk1("wdog.b.relock_vs", b_vs, 1'b1);
    chk1("wdog.b.relocked", b_lock, 1'b1);
    drive(0, 0, 1, 1, 0, 0);
    $display("[%0t] watchdog: hs a=%0d b=%0d, b relocked=%0b", $time, cnt_a, cnt_b, b_lock);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      bit hs_n, vs_n;
      hs_n = ($urandom_range(0, 7) == 0) ? !hs_lvl : hs_lvl;
      vs_n = ($urandom_range(0, 49) == 0) ? !vs_lvl : vs_lvl;
      drive(0, 1'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 9) == 0), hs_n, vs_n);
    end
    drive(0, 0, 1, 1, 0, 0);
    $display("[%0t] random traffic: 400 clks", $time);

    // Full frame measurement: 256 pixels x 224 lines
    vs_event();
    for (int l = 0; l < 224; l++) video_line(256, 0);
    for (int l = 0; l < 2; l++) video_line(20, 1);
    vs_event();
    chk24("meas.a.width", 24'(a_w), 24'd256);
    chk24("meas.a.height", 24'(a_h), 24'd224);
    chk1 ("meas.a.mvalid", a_mv, 1'b1);
    chk1 ("meas.b.mvalid", b_mv, 1'b0);
    $display("[%0t] frame measured: %0dx%0d valid=%0b", $time, a_w, a_h, a_mv);

    // Reset mid-frame
    vs_event();
    video_line(30, 0);
    for (int k = 0; k < 10; k++) drive(0, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    chk1 ("mrst.a.de", a_de, 1'b0);
    chk1 ("mrst.a.locked", a_lock, 1'b0);
    chk24("mrst.a.width", 24'(a_w), 24'h0);
    chk24("mrst.a.height", 24'(a_h), 24'h0);
    cnt_a = 0;
    for (int l = 0; l < 2; l++) begin
      for (int k = 0; k < 30; k++) begin
        drive(0, 1, 0, 0, 0, 0);
        cnt_a += int'(a_de) + int'(b_de);
      end
      drive(0, 0, 1, 0, 1, 0);
      drive(0, 0, 1, 0, 0, 0);
    end
    chk_int("mrst.de_suppressed", cnt_a, 0);
    drive(0, 0, 1, 1, 0, 1);
    chk1("mrst.a.relocked", a_lock, 1'b1);
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    chk1("mrst.a.de_after", a_de, 1'b1);
    $display("[%0t] mid-frame reset: de after reset %0d, relocked=%0b", $time, cnt_a, a_lock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
